// File: rtl/prince_sbox_cms_sched.sv
`default_nettype none
// ============================================================================
// Module   : prince_sbox_cms_sched
// Brief    : Sequencer for one shared 2-share CMS-masked PRINCE S-box. It
//            issues the state one nibble per cycle, gated on fresh
//            randomness, and writes results back in place. The 2-share
//            substituted state is presented afterwards.
// Options  : PRINCE_SCHED_ZEROIZE_EN - clear the share registers when the
//            result is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module prince_sbox_cms_sched #(
   parameter int NIBBLES  = 16,
   parameter int SBOX_LAT = 1,
   parameter int RND_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_sh0,
   input  logic [4*NIBBLES-1:0] in_sh1,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  logic [RND_W-1:0]     rnd,
   output logic [3:0]           sb_x_sh0,
   output logic [3:0]           sb_x_sh1,
   output logic [RND_W-1:0]     sb_rnd,
   output logic                 sb_en,
   input  logic [3:0]           sb_y_sh0,
   input  logic [3:0]           sb_y_sh1,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sh0,
   output logic [4*NIBBLES-1:0] out_sh1
);

   localparam int CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);
   localparam logic [CW-1:0] NIB_CNT  = CW'(NIBBLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state, state_nx;
   logic [4*NIBBLES-1:0]  sh0, sh1;
   logic [CW-1:0]         iss_idx, ret_idx;
   logic [SBOX_LAT-1:0]   vld_sr;
   logic                  issue, load, tail;

   assign tail    = vld_sr[SBOX_LAT-1];
   assign out_sh0 = sh0;
   assign out_sh1 = sh1;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state, issue strobe and handshake outputs; everything is forced
   // quiet while reset is asserted so no stale nibble leaks out
   always_comb begin
      state_nx  = state;
      issue     = 1'b0;
      load      = 1'b0;
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
      sb_en     = 1'b0;
      out_valid = 1'b0;
      sb_x_sh0  = 4'd0;
      sb_x_sh1  = 4'd0;
      sb_rnd    = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  load     = 1'b1;
                  state_nx = RUN;
               end
            end
            RUN: begin
               sb_en = 1'b1;
               if (rnd_valid) begin
                  issue     = 1'b1;
                  rnd_ready = 1'b1;
                  sb_x_sh0  = sh0[{iss_idx, 2'b00} +: 4];
                  sb_x_sh1  = sh1[{iss_idx, 2'b00} +: 4];
                  sb_rnd    = rnd;
                  if (iss_idx == LAST_IDX) state_nx = DRAIN;
               end
            end
            DRAIN: begin
               sb_en = 1'b1;
               if (ret_idx == NIB_CNT) state_nx = DONE;
            end
            DONE: begin
               out_valid = 1'b1;
               if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Issue and writeback nibble counters
   always_ff @(posedge clk) begin
      if (rst || load) begin
         iss_idx <= '0;
         ret_idx <= '0;
      end else begin
         if (issue) iss_idx <= iss_idx + 1'b1;
         if (tail)  ret_idx <= ret_idx + 1'b1;
      end
   end

   // Valid shift register mirroring the S-box pipeline depth
   generate
      if (SBOX_LAT == 1) begin : g_vld_one
         always_ff @(posedge clk) begin
            if (rst) vld_sr <= '0;
            else     vld_sr <= issue;
         end
      end else begin : g_vld_multi
         always_ff @(posedge clk) begin
            if (rst) vld_sr <= '0;
            else     vld_sr <= {vld_sr[SBOX_LAT-2:0], issue};
         end
      end
   endgenerate

   // Share registers: load, in-place writeback, optional clear on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         sh0 <= '0;
         sh1 <= '0;
      end else if (load) begin
         sh0 <= in_sh0;
         sh1 <= in_sh1;
      end else if (tail) begin
         sh0[{ret_idx, 2'b00} +: 4] <= sb_y_sh0;
         sh1[{ret_idx, 2'b00} +: 4] <= sb_y_sh1;
      end
`ifdef PRINCE_SCHED_ZEROIZE_EN
      else if (out_valid && out_ready) begin
         sh0 <= '0;
         sh1 <= '0;
      end
`else
      else begin
         sh0 <= sh0;
         sh1 <= sh1;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_prince_sbox_cms_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_prince_sbox_cms_sched
// Brief    : Self-checking bench. A behavioural 2-share S-box drives the
//            datapath side. Results are compared with nibble-wise PRINCE
//            substitution of the recombined input, and latency with the
//            count of randomness bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prince_sbox_cms_sched;

   localparam int NIBBLES  = 16;
   localparam int SBOX_LAT = 1;
   localparam int RND_W    = 4;
   localparam int W        = 4 * NIBBLES;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_sh0 = '0;
   logic [W-1:0]     in_sh1 = '0;
   logic             rnd_valid = 1'b0;
   logic             rnd_ready;
   logic [RND_W-1:0] rnd = '0;
   logic [3:0]       sb_x_sh0, sb_x_sh1;
   logic [RND_W-1:0] sb_rnd;
   logic             sb_en;
   logic [3:0]       sb_y_sh0, sb_y_sh1;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_sh0, out_sh1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prince_sbox_cms_sched #(
      .NIBBLES (NIBBLES),
      .SBOX_LAT(SBOX_LAT),
      .RND_W   (RND_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sh0   (in_sh0),
      .in_sh1   (in_sh1),
      .rnd_valid(rnd_valid),
      .rnd_ready(rnd_ready),
      .rnd      (rnd),
      .sb_x_sh0 (sb_x_sh0),
      .sb_x_sh1 (sb_x_sh1),
      .sb_rnd   (sb_rnd),
      .sb_en    (sb_en),
      .sb_y_sh0 (sb_y_sh0),
      .sb_y_sh1 (sb_y_sh1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sh0  (out_sh0),
      .out_sh1  (out_sh1)
   );

   // PRINCE S-box lookup, entry 0 in the low nibble
   function automatic logic [3:0] prince_s(input logic [3:0] x);
      logic [63:0] tbl;
      tbl = 64'h4D5E087619CA23FB;
      return tbl[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [W-1:0] sub_state(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < NIBBLES; i++) r[i*4 +: 4] = prince_s(v[i*4 +: 4]);
      return r;
   endfunction

   // Behavioural masked S-box: y0 = S(x0^x1)^m, y1 = m, SBOX_LAT stages
   logic [3:0] p0 [SBOX_LAT];
   logic [3:0] p1 [SBOX_LAT];
   always @(posedge clk) begin
      if (sb_en) begin
         p0[0] <= prince_s(sb_x_sh0 ^ sb_x_sh1) ^ sb_rnd;
         p1[0] <= sb_rnd;
         for (int i = 1; i < SBOX_LAT; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
         end
      end
   end
   assign sb_y_sh0 = p0[SBOX_LAT-1];
   assign sb_y_sh1 = p1[SBOX_LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One full transaction. mode 0: rnd always valid; 1: bubbles on RUN
   // cycles 3, 4, 10; 2: random bubbles. bp = DONE cycles without out_ready.
   task automatic do_op(input string tag, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input int mode, input int bp, input bit rand_rnd);
      int k, valids, t_last, lat, pulses;
      bit rv, gate_bad, hold_bad;
      logic [W-1:0] h0, h1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_sh0 = a0; in_sh1 = a1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sh0 = {$urandom, $urandom};
      in_sh1 = {$urandom, $urandom};
      valids = 0; t_last = 0; lat = -1; pulses = 0; gate_bad = 1'b0;
      for (k = 0; k < 300 && lat < 0; k++) begin
         case (mode)
            0:       rv = 1'b1;
            1:       rv = !((k + 1) == 3 || (k + 1) == 4 || (k + 1) == 10);
            default: rv = ($urandom_range(0, 3) != 0);
         endcase
         rnd_valid = rv;
         rnd = rand_rnd ? RND_W'($urandom) : '0;
         if (rv && valids < NIBBLES) begin
            valids++;
            if (valids == NIBBLES) t_last = k + 1;
         end
         @(negedge clk);
         if (rnd_ready) pulses++;
         if (rnd_ready && !rnd_valid) gate_bad = 1'b1;
         if (!rnd_ready && (sb_x_sh0 != 4'd0 || sb_x_sh1 != 4'd0 || sb_rnd != '0)) gate_bad = 1'b1;
         if (out_valid) lat = k;
         @(posedge clk); #1;
      end
      rnd_valid = 1'b0;
      if (lat < 0) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(t_last + SBOX_LAT + 1));
      chk({tag, "_rnd_pulses"}, 64'(pulses), 64'(NIBBLES));
      chk({tag, "_gating"}, 64'(gate_bad), 64'd0);
      chk({tag, "_result"}, out_sh0 ^ out_sh1, sub_state(a0 ^ a1));
      h0 = out_sh0; h1 = out_sh1; hold_bad = 1'b0;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || out_sh0 !== h0 || out_sh1 !== h1) hold_bad = 1'b1;
         @(posedge clk); #1;
      end
      chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
`ifdef PRINCE_SCHED_ZEROIZE_EN
      chk({tag, "_zeroize"}, out_sh0 | out_sh1, 64'd0);
`else
      chk({tag, "_keep"}, out_sh0 ^ out_sh1, sub_state(a0 ^ a1));
`endif
   endtask

   initial begin
      logic [W-1:0] m, a;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_ctrl", {61'd0, rnd_ready, sb_en, out_valid}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_shares", out_sh0 | out_sh1, 64'd0);
      @(posedge clk); #1;

      do_op("unmasked", 64'h0123456789ABCDEF, 64'd0, 0, 0, 1'b0);
      m = 64'hA5A5A5A5A5A5A5A5;
      do_op("masked", 64'h0123456789ABCDEF ^ m, m, 0, 1, 1'b1);
      do_op("stalls", 64'h0123456789ABCDEF ^ m, m, 1, 0, 1'b1);
      do_op("backpressure", {$urandom, $urandom}, {$urandom, $urandom}, 0, 5, 1'b1);

      // reset in the middle of RUN, then an all-zero state
      in_sh0 = {$urandom, $urandom}; in_sh1 = {$urandom, $urandom}; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rnd_valid = 1'b1;
      repeat (7) begin
         rnd = RND_W'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_quiet", {61'd0, in_ready, rnd_ready, sb_en}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rnd_valid = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      do_op("zero_state", 64'd0, 64'd0, 0, 0, 1'b1);

      // randomized states, masks, bubbles and backpressure
      for (int t = 0; t < 6; t++) begin
         a = {$urandom, $urandom};
         m = {$urandom, $urandom};
         do_op("random", a ^ m, m, 2, $urandom_range(0, 3), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
